// File: rtl/aq_djpeg_pkg.sv
// Shared types and constants for the JPEG decoder input path.
// Entries carry the stream word plus its end-of-file marker.
package aq_djpeg_pkg;

    localparam int AQ_DJPEG_WORD_W          = 32;
    localparam int AQ_DJPEG_FIFO_DEPTH_LOG2 = 4;
    localparam int AQ_DJPEG_COUNT_W         = 32;

    typedef struct packed {
        logic                       last;
        logic [AQ_DJPEG_WORD_W-1:0] data;
    } fifoEntry_t;

    function automatic fifoEntry_t makeEntry(input logic last, input logic [AQ_DJPEG_WORD_W-1:0] data);
        fifoEntry_t e;
        e.last = last;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/aq_djpeg_infifo_if.sv
// Stream-in / pop-out bundle of the input FIFO.
// slave is the FIFO's view; master is the surrounding logic's view.
interface aq_djpeg_infifo_if;

    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;

    logic [31:0] DataIn;
    logic        DataInEnable;
    logic        DataInRead;
    logic        DataInLast;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  DataInRead,
        output s_axis_tready,
        output DataIn,
        output DataInEnable,
        output DataInLast
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output DataInRead,
        input  s_axis_tready,
        input  DataIn,
        input  DataInEnable,
        input  DataInLast
    );

endinterface

// File: rtl/aq_djpeg_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Kept standalone so a vendor RAM macro can replace it.
module aq_djpeg_fifo_ram
    import aq_djpeg_pkg::*;
#(
    parameter int ADDR_W = AQ_DJPEG_FIFO_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  fifoEntry_t        wData,
    input  logic [ADDR_W-1:0] rAddr,
    output fifoEntry_t        rData
);

    fifoEntry_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= wData;
        end
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/aq_djpeg_infifo.sv
// First-word-fall-through input buffer between the AXI4-Stream source and the bit-register stage.
// Stops accepting after a tlast word so the next file cannot mix into the current image.
module aq_djpeg_infifo
    import aq_djpeg_pkg::*;
#(
    parameter int DEPTH_LOG2  = AQ_DJPEG_FIFO_DEPTH_LOG2,
    parameter int COUNT_WIDTH = AQ_DJPEG_COUNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Clear,
    aq_djpeg_infifo_if.slave       bus,
    output logic [DEPTH_LOG2:0]    Level,
    output logic [COUNT_WIDTH-1:0] WordCount,
    output logic                   FrameDone
);

    logic [DEPTH_LOG2:0]   wrPtr;
    logic [DEPTH_LOG2:0]   rdPtr;
    logic                  lastSeen;
    logic                  empty;
    logic                  full;
    logic                  ready;
    logic                  push;
    logic                  pop;
    fifoEntry_t            headEntry;
    fifoEntry_t            inEntry;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]) &&
                   (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]);

    // rst is folded in so the source sees tready low for the whole reset window.
    assign ready = ~full & ~lastSeen & ~Clear & ~rst;
    assign push  = bus.s_axis_tvalid & ready;
    assign pop   = bus.DataInRead & ~empty & ~Clear;

    assign inEntry = makeEntry(bus.s_axis_tlast, bus.s_axis_tdata);

    aq_djpeg_fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .wAddr (wrPtr[DEPTH_LOG2-1:0]),
        .wData (inEntry),
        .rAddr (rdPtr[DEPTH_LOG2-1:0]),
        .rData (headEntry)
    );

    assign bus.s_axis_tready = ready;
    assign bus.DataInEnable  = ~empty;
    assign bus.DataIn        = empty ? '0 : headEntry.data;
    assign bus.DataInLast    = empty ? 1'b0 : headEntry.last;

    // Pointer difference modulo 2^(DEPTH_LOG2+1) spans exactly 0..depth.
    assign Level = wrPtr - rdPtr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            lastSeen  <= 1'b0;
            WordCount <= '0;
            FrameDone <= 1'b0;
        end else if (Clear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            lastSeen  <= 1'b0;
            WordCount <= '0;
            FrameDone <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
                if (bus.s_axis_tlast) begin
                    lastSeen <= 1'b1;
                end
                if (WordCount != {COUNT_WIDTH{1'b1}}) begin
                    WordCount <= WordCount + 1'b1;
                end
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            FrameDone <= pop & headEntry.last;
        end
    end

endmodule

// File: tb/tb_aq_djpeg_infifo.sv
// Directed and randomized bench for aq_djpeg_infifo against a queue-based reference model.
module tb_aq_djpeg_infifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic        clk;
    logic        rst;
    logic        Clear;
    logic [DL2:0] Level;
    logic [31:0] WordCount;
    logic        FrameDone;

    aq_djpeg_infifo_if ifc();

    aq_djpeg_infifo #(
        .DEPTH_LOG2  (DL2),
        .COUNT_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Clear     (Clear),
        .bus       (ifc.slave),
        .Level     (Level),
        .WordCount (WordCount),
        .FrameDone (FrameDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q[$];
    logic [31:0] mWc;
    bit          mLastSeen;
    bit          mFd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic rd, input logic clr);
        bit          push;
        bit          pop;
        bit          expReady;
        logic [32:0] head;
        ifc.s_axis_tvalid = v;
        ifc.s_axis_tdata  = d;
        ifc.s_axis_tlast  = l;
        ifc.DataInRead    = rd;
        Clear             = clr;
        #1;
        head     = (q.size() > 0) ? q[0] : 33'd0;
        expReady = (q.size() < DEPTH) && !mLastSeen && !clr;
        check("tready",       64'(ifc.s_axis_tready), 64'(expReady));
        check("DataInEnable", 64'(ifc.DataInEnable),  64'(q.size() > 0));
        check("DataIn",       64'(ifc.DataIn),        64'(head[31:0]));
        check("DataInLast",   64'(ifc.DataInLast),    64'(head[32]));
        check("Level",        64'(Level),             64'(q.size()));
        check("WordCount",    64'(WordCount),         64'(mWc));
        check("FrameDone",    64'(FrameDone),         64'(mFd));
        push = v && expReady;
        pop  = rd && (q.size() > 0) && !clr;
        @(posedge clk);
        if (clr) begin
            q.delete();
            mWc       = '0;
            mLastSeen = 1'b0;
            mFd       = 1'b0;
        end else begin
            mFd = pop && head[32];
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({l, d});
                if (mWc != 32'hFFFF_FFFF) mWc = mWc + 32'd1;
                if (l) mLastSeen = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        q.delete();
        mWc       = '0;
        mLastSeen = 1'b0;
        mFd       = 1'b0;
        rst               = 1'b1;
        Clear             = 1'b0;
        ifc.s_axis_tvalid = 1'b0;
        ifc.s_axis_tdata  = '0;
        ifc.s_axis_tlast  = 1'b0;
        ifc.DataInRead    = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready",       64'(ifc.s_axis_tready), 64'(0));
        check("rst_DataInEnable", 64'(ifc.DataInEnable),  64'(0));
        check("rst_DataIn",       64'(ifc.DataIn),        64'(0));
        check("rst_Level",        64'(Level),             64'(0));
        check("rst_WordCount",    64'(WordCount),         64'(0));
        check("rst_FrameDone",    64'(FrameDone),         64'(0));
        rst = 1'b0;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Fill to full, blocked 17th word, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        check("full_Level", 64'(Level), 64'(DEPTH));
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Streaming with read every cycle
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
            check("stream_Level_le1", 64'(Level <= 1), 64'(1));
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stream_WordCount", 64'(WordCount), 64'(100));

        // tlast handling
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFD9_CAFE, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("tlast_WordCount", 64'(WordCount), 64'(5));

        // Clear mid-stream with push and pop active
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("preclear_Level", 64'(Level), 64'(7));
        cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Wrap-around with random traffic and empty reads
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++)
                cycle(1'b1 & ($urandom_range(0, 3) != 0), $urandom, 1'b0,
                      ($urandom_range(0, 3) == 0), 1'b0);
            for (int i = 0; i < 40; i++)
                cycle(($urandom_range(0, 3) == 0), $urandom, 1'b0,
                      ($urandom_range(0, 3) != 0), 1'b0);
            for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        check("final_Level", 64'(Level), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_infifo.md
Name: aq_djpeg_infifo

Overview:
Input buffer directly upstream of the bit-register/marker-stripping stage. Accepts compressed JPEG words over a 32-bit AXI4-Stream slave. Buffers them in a first-word-fall-through FIFO and presents them on the DataIn / DataInEnable / DataInRead pop handshake that the register stage consumes. Also tracks end-of-frame (tlast) and word counts so the top level can sequence images.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (depth = 16); legal range 2..10
COUNT_WIDTH, 32, width of the received-word counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
Clear  input  1  synchronous flush of FIFO, counters and flags (driven at end of image / when idle)
s_axis_tdata  input  32  compressed stream word; byte order passed through unchanged
s_axis_tvalid  input  1  stream word valid
s_axis_tready  output  1  FIFO can accept a word
s_axis_tlast  input  1  last word of JPEG file
DataIn  output  32  head-of-FIFO word
DataInEnable  output  1  FIFO not empty; DataIn valid
DataInRead  input  1  pop request from the register stage
DataInLast  output  1  tlast flag of the head word; qualified by DataInEnable
Level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
WordCount  output  COUNT_WIDTH  words accepted since reset/Clear; saturates at all-ones
FrameDone  output  1  one-cycle pulse when the tlast word is popped

Behaviour:
- Reset (rst high, async): pointers = 0, Level = 0, WordCount = 0, FrameDone = 0, s_axis_tready = 0 while rst is asserted, DataInEnable = 0, DataIn = 0, DataInLast = 0, LastSeen = 0.
- Storage: 2^DEPTH_LOG2 entries of 33 bits ({tlast, tdata}).
  - Read and write pointers are DEPTH_LOG2+1 bits each, including a wrap bit.
  - Empty when the pointers are equal. Full when the indices are equal and the wrap bits differ.
- Push = s_axis_tvalid & s_axis_tready.
  - s_axis_tready = ~full & ~LastSeen & ~Clear.
  - After a tlast word is accepted, LastSeen = 1 and no further words are accepted until Clear. This prevents the next file from mixing into the current image.
- Pop = DataInRead & ~empty. DataInRead while empty is ignored with no state change.
- Output timing is first-word-fall-through. DataIn, DataInEnable and DataInLast follow the head entry combinationally from registered state.
  - A word pushed in cycle N is visible at DataIn in cycle N+1 (latency 1).
  - DataIn and DataInLast read 0 when empty.
- Simultaneous push and pop:
  - Allowed when neither full nor empty; Level is unchanged.
  - When full, push is blocked (tready = 0) and pop proceeds.
  - When empty, pop is ignored and push proceeds.
- Level: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds 2^DEPTH_LOG2 and never goes below 0.
- WordCount: +1 per push; holds at 2^COUNT_WIDTH-1.
- FrameDone: registered, high for exactly one cycle after a pop of an entry whose tlast = 1.
- Clear (synchronous, highest priority after rst):
  - Pointers, Level, WordCount, LastSeen and FrameDone go to 0.
  - Any push or pop in the same cycle is discarded.
  - s_axis_tready is 0 during the Clear cycle and re-asserts the following cycle.
- Reset mid-transfer: all state is lost. The upstream master must re-send from the start of the file.
- No byte-stuffing, marker parsing or byte swapping here. All of that stays in the downstream register stage.

Decomposition:
- Shared package aq_djpeg_pkg holds:
  - AQ_DJPEG_WORD_W = 32
  - default FIFO depth constant
  - the 33-bit entry typedef {last, data}
- One sub-module, aq_djpeg_fifo_ram: simple dual-port array, one write port, asynchronous read. It is kept separate so it can be swapped for a vendor RAM.
- Pointer, flag and counter logic lives in aq_djpeg_infifo.

Test Plan:
1. Reset/idle: assert rst with no stimulus -> tready = 0 during rst; after release tready = 1, DataInEnable = 0, Level = 0, WordCount = 0.
2. Fill to full: push 16 words 0x00000000..0x0000000F, no reads -> Level = 16, tready = 0 after 16th word; 17th tvalid held and not accepted; pop all -> DataIn order 0x0..0xF, then empty.
3. Streaming: continuous tvalid with DataInRead = 1 every cycle, 100 words -> Level stays ≤ 1, WordCount = 100, output sequence matches input exactly; one-cycle push-to-DataInEnable latency.
4. tlast: push 5 words with tlast on 0xFFD9CAFE -> tready drops after it; when that word pops, DataInLast = 1 and FrameDone pulses once the next cycle; further tvalid is not accepted.
5. Clear mid-stream: Level = 7 with tvalid and DataInRead both active during the Clear cycle -> next cycle Level = 0, WordCount = 0, DataInEnable = 0, LastSeen cleared, tready = 1.
6. Wrap-around and underflow: 3 × 16-word fill/drain cycles with random tvalid/DataInRead, plus DataInRead on empty -> no data loss or duplication, Level matches the scoreboard, no state change on empty pop.
